// File: rtl/bist_lfsr_misr_engine_if.sv
// Interface between the BIST data-register chain, the CUT, and the LFSR/MISR engine.
// The master modport is the engine side.
interface bist_lfsr_misr_engine_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             cfg_start;
  logic [WIDTH-1:0] cfg_seed;
  logic [CNT_W-1:0] cfg_count;
  logic [WIDTH-1:0] cfg_expected;
  logic [WIDTH-1:0] cut_pattern;
  logic             cut_valid;
  logic [WIDTH-1:0] cut_response;
  logic             busy;
  logic             done;
  logic             pass;
  logic             aborted;
  logic [WIDTH-1:0] signature;

  modport master (
    input  cfg_start, cfg_seed, cfg_count, cfg_expected, cut_response,
    output cut_pattern, cut_valid, busy, done, pass, aborted, signature
  );

  modport slave (
    output cfg_start, cfg_seed, cfg_count, cfg_expected, cut_response,
    input  cut_pattern, cut_valid, busy, done, pass, aborted, signature
  );
endinterface

// File: rtl/bist_lfsr_misr_engine.sv
// BIST execution engine: drives LFSR patterns into the CUT, compacts the responses in a MISR,
// and reports signature and pass/done/aborted status back to the data-register chain.
module bist_lfsr_misr_engine #(
  parameter int unsigned     WIDTH = 8,
  parameter int unsigned     CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(8'hB8)
) (
  input logic                   clk,
  input logic                   reset,
  bist_lfsr_misr_engine_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] lfsr, lfsr_d;
  logic [WIDTH-1:0] misr, misr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             done, done_d;
  logic             pass, pass_d;
  logic             aborted, aborted_d;
  logic             cut_valid, cut_valid_d;
  logic             busy, busy_d;
  logic             start_d;
  logic             resp_en;

  logic             start_edge_c;
  logic [WIDTH-1:0] lfsr_next_c;
  logic [WIDTH-1:0] misr_upd_c;

  assign start_edge_c = bus.cfg_start & ~start_d;
  assign lfsr_next_c  = {lfsr[WIDTH-2:0], ^(lfsr & POLY)};
  // MISR only absorbs a response in the cycle after a live pattern
  assign misr_upd_c   = resp_en ? ({misr[WIDTH-2:0], ^(misr & POLY)} ^ bus.cut_response) : misr;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= '0;
      misr      <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      aborted   <= 1'b0;
      cut_valid <= 1'b0;
      busy      <= 1'b0;
      start_d   <= 1'b0;
      resp_en   <= 1'b0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      misr      <= misr_d;
      cnt       <= cnt_d;
      exp_q     <= exp_d;
      done      <= done_d;
      pass      <= pass_d;
      aborted   <= aborted_d;
      cut_valid <= cut_valid_d;
      busy      <= busy_d;
      start_d   <= bus.cfg_start;
      resp_en   <= cut_valid;
    end
  end

  // Next-state and next-register values; done/pass are set on entry to DONE
  always_comb begin
    state_d   = state;
    lfsr_d    = lfsr;
    misr_d    = misr;
    cnt_d     = cnt;
    exp_d     = exp_q;
    done_d    = done;
    pass_d    = pass;
    aborted_d = aborted;

    unique case (state)
      IDLE: begin
        if (start_edge_c) state_d = INIT;
      end
      INIT, RUN, FLUSH: begin
        if (!bus.cfg_start) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end else if (state == INIT) begin
          // an all-zero seed would lock the LFSR up
          lfsr_d    = (bus.cfg_seed == '0) ? WIDTH'(1) : bus.cfg_seed;
          misr_d    = '0;
          cnt_d     = bus.cfg_count;
          exp_d     = bus.cfg_expected;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          aborted_d = 1'b0;
          if (bus.cfg_count != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (bus.cfg_expected == '0);
          end
        end else if (state == RUN) begin
          lfsr_d = lfsr_next_c;
          misr_d = misr_upd_c;
          cnt_d  = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_d = FLUSH;
        end else begin
          misr_d  = misr_upd_c;
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (misr_upd_c == exp_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cut_valid_d = (state_d == RUN);
    busy_d      = (state_d == INIT) || (state_d == RUN) || (state_d == FLUSH);
  end

  assign bus.cut_pattern = lfsr;
  assign bus.cut_valid   = cut_valid;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.aborted     = aborted;
  assign bus.signature   = misr;

endmodule

// File: tb/tb_bist_lfsr_misr_engine.sv
// Directed bench for bist_lfsr_misr_engine at WIDTH=4, POLY=4'b1001 with hand-computed
// patterns and signatures.
module tb_bist_lfsr_misr_engine;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 16;

  logic clk;
  logic reset;
  logic tie_zero;
  logic [WIDTH-1:0] resp_q;
  int n_checks;
  int n_fail;

  bist_lfsr_misr_engine_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  bist_lfsr_misr_engine #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .POLY (4'b1001)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CUT model: response is the pattern delayed one cycle, or tied to zero
  always @(posedge clk) resp_q <= bus.cut_pattern;
  assign bus.cut_response = tie_zero ? '0 : resp_q;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    tie_zero         = 1'b1;
    bus.cfg_start    = 1'b0;
    bus.cfg_seed     = '0;
    bus.cfg_count    = '0;
    bus.cfg_expected = '0;
    step(2);
    check("rst_pattern",   32'(bus.cut_pattern), 32'h0);
    check("rst_valid",     32'(bus.cut_valid),   32'h0);
    check("rst_busy",      32'(bus.busy),        32'h0);
    check("rst_done",      32'(bus.done),        32'h0);
    check("rst_pass",      32'(bus.pass),        32'h0);
    check("rst_aborted",   32'(bus.aborted),     32'h0);
    check("rst_signature", 32'(bus.signature),   32'h0);
    reset = 1'b0;
    step(1);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // T1: seed 1, N=3, response tied low
    bus.cfg_seed = 4'h1; bus.cfg_count = 16'd3; bus.cfg_expected = 4'h0;
    bus.cfg_start = 1'b1;
    step(1);
    check("t1_init_busy",  32'(bus.busy),      32'h1);
    check("t1_init_valid", 32'(bus.cut_valid), 32'h0);
    step(1);
    check("t1_valid0", 32'(bus.cut_valid),   32'h1);
    check("t1_pat0",   32'(bus.cut_pattern), 32'h1);
    step(1);
    check("t1_pat1",   32'(bus.cut_pattern), 32'h3);
    step(1);
    check("t1_pat2",   32'(bus.cut_pattern), 32'h7);
    check("t1_valid2", 32'(bus.cut_valid),   32'h1);
    step(1);
    check("t1_flush_valid", 32'(bus.cut_valid), 32'h0);
    check("t1_flush_busy",  32'(bus.busy),      32'h1);
    check("t1_flush_done",  32'(bus.done),      32'h0);
    step(1);
    check("t1_done",      32'(bus.done),      32'h1);
    check("t1_signature", 32'(bus.signature), 32'h0);
    check("t1_pass",      32'(bus.pass),      32'h1);
    check("t1_busy",      32'(bus.busy),      32'h0);
    bus.cfg_start = 1'b0;
    step(2);
    check("t1_done_sticky", 32'(bus.done), 32'h1);

    // T3: zero seed is forced to 1
    bus.cfg_seed = 4'h0; bus.cfg_count = 16'd2;
    bus.cfg_start = 1'b1;
    step(2);
    check("t3_pat0", 32'(bus.cut_pattern), 32'h1);
    check("t3_done_cleared", 32'(bus.done), 32'h0);
    step(1);
    check("t3_pat1", 32'(bus.cut_pattern), 32'h3);
    step(1);
    check("t3_flush_valid", 32'(bus.cut_valid), 32'h0);
    step(1);
    check("t3_done", 32'(bus.done), 32'h1);
    bus.cfg_start = 1'b0;
    step(2);

    // T2: response follows the pattern, golden signature 7
    tie_zero = 1'b0;
    bus.cfg_seed = 4'h1; bus.cfg_count = 16'd3; bus.cfg_expected = 4'h7;
    bus.cfg_start = 1'b1;
    step(6);
    check("t2a_done",      32'(bus.done),      32'h1);
    check("t2a_signature", 32'(bus.signature), 32'h7);
    check("t2a_pass",      32'(bus.pass),      32'h1);
    bus.cfg_start = 1'b0;
    step(2);
    bus.cfg_expected = 4'h6;
    bus.cfg_start = 1'b1;
    step(2);
    check("t2b_done_cleared", 32'(bus.done), 32'h0);
    step(4);
    check("t2b_done",      32'(bus.done),      32'h1);
    check("t2b_signature", 32'(bus.signature), 32'h7);
    check("t2b_pass",      32'(bus.pass),      32'h0);
    bus.cfg_start = 1'b0;
    step(2);

    // T4: N=0 finishes two cycles after the start edge with an empty signature
    bus.cfg_seed = 4'h5; bus.cfg_count = 16'd0; bus.cfg_expected = 4'h3;
    bus.cfg_start = 1'b1;
    step(1);
    check("t4_init_valid", 32'(bus.cut_valid), 32'h0);
    step(1);
    check("t4_done",      32'(bus.done),      32'h1);
    check("t4_valid",     32'(bus.cut_valid), 32'h0);
    check("t4_signature", 32'(bus.signature), 32'h0);
    check("t4_pass",      32'(bus.pass),      32'h0);
    bus.cfg_start = 1'b0;
    step(2);

    // T5: abort on the 10th RUN cycle of a 100-pattern run
    bus.cfg_seed = 4'h1; bus.cfg_count = 16'd100; bus.cfg_expected = 4'h0;
    bus.cfg_start = 1'b1;
    step(2);
    step(9);
    check("t5_run_busy",  32'(bus.busy),      32'h1);
    check("t5_run_valid", 32'(bus.cut_valid), 32'h1);
    bus.cfg_start = 1'b0;
    step(1);
    check("t5_aborted", 32'(bus.aborted),   32'h1);
    check("t5_done",    32'(bus.done),      32'h0);
    check("t5_busy",    32'(bus.busy),      32'h0);
    check("t5_valid",   32'(bus.cut_valid), 32'h0);
    check("t5_pass",    32'(bus.pass),      32'h0);
    step(2);

    // T6: reset mid-run clears everything; a new start gives a full run
    bus.cfg_seed = 4'h1; bus.cfg_count = 16'd100; bus.cfg_expected = 4'h7;
    bus.cfg_start = 1'b1;
    step(4);
    reset = 1'b1;
    step(1);
    check("t6_pattern",   32'(bus.cut_pattern), 32'h0);
    check("t6_valid",     32'(bus.cut_valid),   32'h0);
    check("t6_busy",      32'(bus.busy),        32'h0);
    check("t6_done",      32'(bus.done),        32'h0);
    check("t6_aborted",   32'(bus.aborted),     32'h0);
    check("t6_signature", 32'(bus.signature),   32'h0);
    reset = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_count = 16'd3;
    step(1);
    bus.cfg_start = 1'b1;
    step(2);
    check("t6_pat0", 32'(bus.cut_pattern), 32'h1);
    step(4);
    check("t6_done",      32'(bus.done),      32'h1);
    check("t6_sig_final", 32'(bus.signature), 32'h7);
    check("t6_pass",      32'(bus.pass),      32'h1);
    bus.cfg_start = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
